// File: rtl/mac_pkg.sv
// Shared definitions for the MAC processing element: FSM states, dataflow
// mode encoding and instruction bit positions.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        ACC   = 2'd3
    } state_t;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;

endpackage

// File: rtl/mac_mul_add.sv
// Combinational act*wgt + addend with a selectable signed/unsigned activation.
// Build option: MAC_PE_SAT_EN clamps the sum to the signed PSUM_BW range.
module mac_mul_add #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
) (
    input  logic [BW-1:0]      act,
    input  logic [BW-1:0]      wgt,
    input  logic [PSUM_BW-1:0] addend,
    input  logic               act_signed,
    output logic [PSUM_BW-1:0] sum
);
    localparam int PROD_BW = 2*BW + 1;

    logic signed [BW:0]         act_ext;
    logic signed [PROD_BW-1:0]  act_x;
    logic signed [PROD_BW-1:0]  wgt_x;
    logic signed [PROD_BW-1:0]  prod;

    // A BW+1 bit activation keeps 2^BW-1 positive in unsigned mode.
    assign act_ext = {act_signed & act[BW-1], act};
    assign act_x   = {{(PROD_BW-BW-1){act_ext[BW]}}, act_ext};
    assign wgt_x   = {{(BW+1){wgt[BW-1]}}, wgt};
    assign prod    = act_x * wgt_x;

`ifdef MAC_PE_SAT_EN
    // One guard bit above the wider of product and addend so the sum never wraps.
    localparam int EXT_BW = ((PSUM_BW > PROD_BW) ? PSUM_BW : PROD_BW) + 1;

    logic signed [EXT_BW-1:0] prod_x;
    logic signed [EXT_BW-1:0] add_x;
    logic signed [EXT_BW-1:0] full;
    logic signed [EXT_BW-1:0] max_x;
    logic signed [EXT_BW-1:0] min_x;

    assign prod_x = {{(EXT_BW-PROD_BW){prod[PROD_BW-1]}}, prod};
    assign add_x  = {{(EXT_BW-PSUM_BW){addend[PSUM_BW-1]}}, addend};
    assign full   = prod_x + add_x;
    assign max_x  = {{(EXT_BW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    assign min_x  = {{(EXT_BW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};

    always_comb begin
        sum = full[PSUM_BW-1:0];
        if (full > max_x)
            sum = {1'b0, {(PSUM_BW-1){1'b1}}};
        else if (full < min_x)
            sum = {1'b1, {(PSUM_BW-1){1'b0}}};
    end
`else
    logic [PSUM_BW-1:0] prod_p;

    if (PSUM_BW > PROD_BW) begin : g_ext
        assign prod_p = {{(PSUM_BW-PROD_BW){prod[PROD_BW-1]}}, prod};
    end else begin : g_trunc
        assign prod_p = prod[PSUM_BW-1:0];
    end

    assign sum = prod_p + addend;
`endif

endmodule

// File: rtl/mac_pe.sv
// Systolic MAC processing element supporting weight-stationary and
// output-stationary dataflow. Build option: MAC_PE_SAT_EN (saturating sums).
module mac_pe
    import mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [1:0]         inst,
    input  logic               drain,
    input  logic [BW-1:0]      in_w,
    input  logic               in_w_valid,
    input  logic [PSUM_BW-1:0] in_n,
    input  logic               in_n_valid,
    output logic [BW-1:0]      out_e,
    output logic               out_e_valid,
    output logic [PSUM_BW-1:0] out_s,
    output logic               out_s_valid,
    output logic               busy
);
    state_t             state;
    state_t             state_nxt;
    logic               mode_r;
    logic               eff_mode;
    logic [BW-1:0]      weight;
    logic [PSUM_BW-1:0] acc;
    logic               both_v;
    logic               is_acc;
    logic [BW-1:0]      ma_wgt;
    logic [PSUM_BW-1:0] ma_add;
    logic [PSUM_BW-1:0] ma_sum;

    // mode is only observed while idle; afterwards the latched copy rules.
    assign eff_mode = (state == IDLE) ? mode : mode_r;
    assign both_v   = in_w_valid & in_n_valid;
    assign is_acc   = (state == ACC);
    assign busy     = (state != IDLE);

    // One multiply-add serves both modes: WS uses the stored weight and the
    // northern psum, OS uses the streamed weight and the local accumulator.
    assign ma_wgt = is_acc ? in_n[BW-1:0] : weight;
    assign ma_add = is_acc ? acc : in_n;

    mac_mul_add #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW)
    ) u_mul_add (
        .act        (in_w),
        .wgt        (ma_wgt),
        .addend     (ma_add),
        .act_signed (is_acc),
        .sum        (ma_sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (eff_mode == MODE_OS && inst[INST_EXEC])
                    state_nxt = ACC;
                else if (eff_mode == MODE_WS && inst[INST_LOAD])
                    state_nxt = LOAD;
            end
            LOAD:    if (in_w_valid)     state_nxt = READY;
            READY:   if (inst == 2'b00)  state_nxt = IDLE;
            ACC:     if (drain)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode_r      <= MODE_WS;
            weight      <= '0;
            acc         <= '0;
            out_e       <= '0;
            out_e_valid <= 1'b0;
            out_s       <= '0;
            out_s_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                mode_r <= mode;

            // The weight beat captured in LOAD is consumed, not passed east.
            out_e       <= in_w;
            out_e_valid <= in_w_valid & (state != LOAD);

            case (state)
                LOAD: begin
                    out_s_valid <= 1'b0;
                    if (in_w_valid)
                        weight <= in_w;
                end
                READY: begin
                    out_s_valid <= inst[INST_EXEC] & both_v;
                    if (inst[INST_EXEC] & both_v)
                        out_s <= ma_sum;
                end
                ACC: begin
                    if (drain) begin
                        out_s       <= both_v ? ma_sum : acc;
                        out_s_valid <= 1'b1;
                        acc         <= '0;
                    end else begin
                        if (both_v)
                            acc <= ma_sum;
                        out_s       <= {{(PSUM_BW-BW){in_n[BW-1]}}, in_n[BW-1:0]};
                        out_s_valid <= in_n_valid;
                    end
                end
                default: out_s_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe: per-cycle vector table through a scoreboard
// queue, plus hand sequences for overflow and mid-operation reset.
module tb_mac_pe;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  inst;
    logic        drain;
    logic [3:0]  in_w;
    logic        in_w_valid;
    logic [15:0] in_n;
    logic        in_n_valid;

    logic [3:0]  out_e, out_e8;
    logic        out_e_valid, out_e_valid8;
    logic [15:0] out_s;
    logic [7:0]  out_s8;
    logic        out_s_valid, out_s_valid8;
    logic        busy, busy8;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef MAC_PE_SAT_EN
    localparam logic [7:0] OVF_EXP = 8'h7F;
`else
    localparam logic [7:0] OVF_EXP = 8'h93;
`endif

    always #5 clk = ~clk;

    mac_pe #(.BW(4), .PSUM_BW(16)) u_dut (
        .clk(clk), .reset(reset), .mode(mode), .inst(inst), .drain(drain),
        .in_w(in_w), .in_w_valid(in_w_valid), .in_n(in_n), .in_n_valid(in_n_valid),
        .out_e(out_e), .out_e_valid(out_e_valid), .out_s(out_s),
        .out_s_valid(out_s_valid), .busy(busy)
    );

    mac_pe #(.BW(4), .PSUM_BW(8)) u_dut8 (
        .clk(clk), .reset(reset), .mode(mode), .inst(inst), .drain(drain),
        .in_w(in_w), .in_w_valid(in_w_valid), .in_n(in_n[7:0]), .in_n_valid(in_n_valid),
        .out_e(out_e8), .out_e_valid(out_e_valid8), .out_s(out_s8),
        .out_s_valid(out_s_valid8), .busy(busy8)
    );

    typedef struct {
        logic        md;
        logic [1:0]  in;
        logic        dr;
        logic [3:0]  w;
        logic        wv;
        logic [15:0] n;
        logic        nv;
        logic        ev;
        logic [3:0]  e;
        logic        sv;
        logic [15:0] s;
        logic        b;
    } vec_t;

    typedef struct {
        logic        ev;
        logic [3:0]  e;
        logic        sv;
        logic [15:0] s;
        logic        b;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(logic md, logic [1:0] in, logic dr, logic [3:0] w, logic wv,
                                logic [15:0] n, logic nv, logic ev, logic [3:0] e,
                                logic sv, logic [15:0] s, logic b);
        vec_t r;
        r.md = md; r.in = in; r.dr = dr; r.w = w; r.wv = wv; r.n = n; r.nv = nv;
        r.ev = ev; r.e = e; r.sv = sv; r.s = s; r.b = b;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic md, input logic [1:0] in, input logic dr,
                         input logic [3:0] w, input logic wv, input logic [15:0] n, input logic nv);
        mode = md; inst = in; drain = dr; in_w = w; in_w_valid = wv; in_n = n; in_n_valid = nv;
    endtask

    task automatic step(input logic md, input logic [1:0] in, input logic dr,
                        input logic [3:0] w, input logic wv, input logic [15:0] n, input logic nv);
        @(negedge clk);
        drive(md, in, dr, w, wv, n, nv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t x;
        reset = 1'b0;
        drive(0, 2'b00, 0, 4'h0, 0, 16'h0, 0);

        // WS load/forward: weight 3 captured, 5 and 7 forwarded, exec proves weight
        tbl.push_back(mk(0, 2'b01, 0, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b01, 0, 4'h3, 1, 16'd0,   0, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b01, 0, 4'h5, 1, 16'd0,   0, 1, 4'h5, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b01, 0, 4'h7, 1, 16'd0,   0, 1, 4'h7, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b10, 0, 4'h1, 1, 16'd0,   1, 1, 4'h1, 1, 16'd3,    1));
        tbl.push_back(mk(0, 2'b00, 0, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    0));
        // WS execute with weight -2 and unsigned activation 15
        tbl.push_back(mk(0, 2'b01, 0, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b01, 0, 4'hE, 1, 16'd0,   0, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b10, 0, 4'hF, 1, 16'd100, 1, 1, 4'hF, 1, 16'd70,   1));
        tbl.push_back(mk(0, 2'b10, 0, 4'hF, 1, 16'd100, 0, 1, 4'hF, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b10, 0, 4'hF, 0, 16'd100, 1, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(0, 2'b00, 0, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    0));
        // ignored commands in IDLE
        tbl.push_back(mk(0, 2'b10, 0, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    0));
        tbl.push_back(mk(1, 2'b01, 0, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    0));
        tbl.push_back(mk(0, 2'b00, 1, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    0));
        // OS: (2,3) (-4,5) (7,-1) then drain -> -21; mode flips mid-run
        tbl.push_back(mk(1, 2'b10, 0, 4'h0, 0, 16'd0,   0, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(1, 2'b00, 0, 4'h2, 1, 16'h3,   1, 1, 4'h2, 1, 16'h0003, 1));
        tbl.push_back(mk(1, 2'b00, 0, 4'hC, 1, 16'h5,   1, 1, 4'hC, 1, 16'h0005, 1));
        tbl.push_back(mk(0, 2'b00, 0, 4'h7, 1, 16'hF,   1, 1, 4'h7, 1, 16'hFFFF, 1));
        tbl.push_back(mk(0, 2'b00, 1, 4'h0, 0, 16'h0,   0, 0, 4'h0, 1, 16'hFFEB, 0));
        tbl.push_back(mk(0, 2'b00, 0, 4'h0, 0, 16'h0,   0, 0, 4'h0, 0, 16'd0,    0));
        // accumulator cleared by drain
        tbl.push_back(mk(1, 2'b10, 0, 4'h0, 0, 16'h0,   0, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(1, 2'b00, 1, 4'h0, 0, 16'h0,   0, 0, 4'h0, 1, 16'd0,    0));
        // drain coincident with (1,1) on accumulator 10
        tbl.push_back(mk(1, 2'b10, 0, 4'h0, 0, 16'h0,   0, 0, 4'h0, 0, 16'd0,    1));
        tbl.push_back(mk(1, 2'b00, 0, 4'h2, 1, 16'h5,   1, 1, 4'h2, 1, 16'h0005, 1));
        tbl.push_back(mk(1, 2'b00, 1, 4'h1, 1, 16'h1,   1, 1, 4'h1, 1, 16'd11,   0));
        tbl.push_back(mk(0, 2'b00, 0, 4'h0, 0, 16'h0,   0, 0, 4'h0, 0, 16'd0,    0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_e",       {28'd0, out_e},       32'd0);
        chk("rst_out_e_valid", {31'd0, out_e_valid}, 32'd0);
        chk("rst_out_s",       {16'd0, out_s},       32'd0);
        chk("rst_out_s_valid", {31'd0, out_s_valid}, 32'd0);
        chk("rst_busy",        {31'd0, busy},        32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].md, tbl[i].in, tbl[i].dr, tbl[i].w, tbl[i].wv, tbl[i].n, tbl[i].nv);
            x.ev = tbl[i].ev; x.e = tbl[i].e; x.sv = tbl[i].sv; x.s = tbl[i].s; x.b = tbl[i].b;
            sb.push_back(x);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            chk($sformatf("v%0d_e_valid", i), {31'd0, out_e_valid}, {31'd0, x.ev});
            if (x.ev) chk($sformatf("v%0d_out_e", i), {28'd0, out_e}, {28'd0, x.e});
            chk($sformatf("v%0d_s_valid", i), {31'd0, out_s_valid}, {31'd0, x.sv});
            if (x.sv) chk($sformatf("v%0d_out_s", i), {16'd0, out_s}, {16'd0, x.s});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, x.b});
        end

        // overflow: 7*7 three times on an 8-bit accumulator
        step(1, 2'b10, 0, 4'h0, 0, 16'h0, 0);
        repeat (3) step(1, 2'b00, 0, 4'h7, 1, 16'h7, 1);
        step(1, 2'b00, 1, 4'h0, 0, 16'h0, 0);
        chk("ovf8_s_valid", {31'd0, out_s_valid8}, 32'd1);
        chk("ovf8_out_s",   {24'd0, out_s8},       {24'd0, OVF_EXP});
        chk("ovf16_out_s",  {16'd0, out_s},        32'd147);
        chk("ovf8_busy",    {31'd0, busy8},        32'd0);
        step(0, 2'b00, 0, 4'h0, 0, 16'h0, 0);
        chk("ovf8_one_pulse", {31'd0, out_s_valid8}, 32'd0);

        // reset in the middle of accumulation
        step(1, 2'b10, 0, 4'h0, 0, 16'h0, 0);
        step(1, 2'b00, 0, 4'h3, 1, 16'h3, 1);
        step(1, 2'b00, 0, 4'h2, 1, 16'h2, 1);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        chk("mid_sv_before",   {31'd0, out_s_valid}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_out_e",       {28'd0, out_e},       32'd0);
        chk("mid_out_e_valid", {31'd0, out_e_valid}, 32'd0);
        chk("mid_out_s",       {16'd0, out_s},       32'd0);
        chk("mid_out_s_valid", {31'd0, out_s_valid}, 32'd0);
        chk("mid_busy",        {31'd0, busy},        32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 2'b00, 0, 4'h0, 0, 16'h0, 0);
        @(posedge clk);
        #1;
        chk("mid_no_pulse", {31'd0, out_s_valid}, 32'd0);
        chk("mid_idle",     {31'd0, busy},        32'd0);
        step(1, 2'b10, 0, 4'h0, 0, 16'h0, 0);
        step(1, 2'b00, 0, 4'h1, 1, 16'h5, 1);
        step(1, 2'b00, 1, 4'h0, 0, 16'h0, 0);
        chk("mid_restart_sv", {31'd0, out_s_valid}, 32'd1);
        chk("mid_restart_s",  {16'd0, out_s},       32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
